// File: rtl/ram_arbiter_pkg.sv
// Shared definitions for the two-port RAM arbiter: port indices, winner
// encoding and the wait-counter width helper.
package ram_arbiter_pkg;

   localparam logic ARB_P_CPU = 1'b0;
   localparam logic ARB_P_AUX = 1'b1;

   typedef enum logic [1:0] {
      WIN_IDLE = 2'd0,
      WIN_CPU  = 2'd1,
      WIN_AUX  = 2'd2
   } win_e;

   // A zero MAX_WAIT still needs a 1-bit counter so the port stays legal.
   function automatic int cnt_width(input int max_wait);
      return (max_wait < 1) ? 1 : $clog2(max_wait + 1);
   endfunction

endpackage

// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters, the arbiter and the single-port RAM.
interface ram_arbiter_if #(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 14
) ();

   logic                     req0;
   logic                     req1;
   logic                     we0;
   logic                     we1;
   logic [ADDRESS_WIDTH-1:0] addr0;
   logic [ADDRESS_WIDTH-1:0] addr1;
   logic [DATA_WIDTH-1:0]    wdata0;
   logic [DATA_WIDTH-1:0]    wdata1;
   logic                     gnt0;
   logic                     gnt1;
   logic                     rvalid0;
   logic                     rvalid1;
   logic [DATA_WIDTH-1:0]    rdata;
   logic                     ram_we;
   logic [ADDRESS_WIDTH-1:0] ram_addr;
   logic [DATA_WIDTH-1:0]    ram_din;
   logic [DATA_WIDTH-1:0]    ram_dout;

   modport slave (
      input  req0, req1, we0, we1, addr0, addr1, wdata0, wdata1, ram_dout,
      output gnt0, gnt1, rvalid0, rvalid1, rdata, ram_we, ram_addr, ram_din
   );

   modport master (
      output req0, req1, we0, we1, addr0, addr1, wdata0, wdata1,
      input  gnt0, gnt1, rvalid0, rvalid1, rdata
   );

   modport mem (
      input  ram_we, ram_addr, ram_din,
      output ram_dout
   );

endinterface

// File: rtl/ram_arbiter_sat_counter.sv
// Saturating up-counter with synchronous clear; counts denied port 1 cycles.
module ram_arbiter_sat_counter #(
   parameter int WIDTH = 3,
   parameter int MAX   = 4
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             clr,
   input  logic             inc,
   output logic [WIDTH-1:0] cnt
);

   localparam logic [WIDTH-1:0] MAX_V = WIDTH'(MAX);

   always_ff @(posedge clk) begin
      if (reset || clr) begin
         cnt <= '0;
      end else if (inc && (cnt != MAX_V)) begin
         cnt <= cnt + 1'b1;
      end
   end

endmodule

// File: rtl/ram_arbiter.sv
// Shares one single-port synchronous RAM between the CPU (port 0, fixed
// priority) and an auxiliary master (port 1) with a starvation guard.
module ram_arbiter
   import ram_arbiter_pkg::*;
#(
   parameter int DATA_WIDTH    = 8,
   parameter int ADDRESS_WIDTH = 14,
   parameter int MAX_WAIT      = 4
) (
   input  logic         clk,
   input  logic         reset,
   ram_arbiter_if.slave bus
);

   localparam int               CNT_W = cnt_width(MAX_WAIT);
   localparam logic [CNT_W-1:0] MAX_V = CNT_W'(MAX_WAIT);

   win_e                     win;
   logic                     force1;
   logic                     gnt0;
   logic                     gnt1;
   logic                     we_win;
   logic                     rd_pending;
   logic                     rd_port;
   logic [CNT_W-1:0]         wait_cnt;
   logic [ADDRESS_WIDTH-1:0] addr_mux;
   logic [DATA_WIDTH-1:0]    din_mux;

   assign force1 = (MAX_WAIT != 0) && (wait_cnt == MAX_V);

   always_comb begin
      win = WIN_IDLE;
      if (!reset) begin
         if (bus.req1 && force1) begin
            win = WIN_AUX;
         end else if (bus.req0) begin
            win = WIN_CPU;
         end else if (bus.req1) begin
            win = WIN_AUX;
         end
      end
   end

   assign gnt0 = (win == WIN_CPU);
   assign gnt1 = (win == WIN_AUX);

   // Idle falls back to port 0 so the CPU address path stays static.
   assign we_win   = gnt1 ? bus.we1    : bus.we0;
   assign addr_mux = gnt1 ? bus.addr1  : bus.addr0;
   assign din_mux  = gnt1 ? bus.wdata1 : bus.wdata0;

   assign bus.gnt0     = gnt0;
   assign bus.gnt1     = gnt1;
   assign bus.ram_we   = we_win & (gnt0 | gnt1);
   assign bus.ram_addr = addr_mux;
   assign bus.ram_din  = din_mux;

   ram_arbiter_sat_counter #(
      .WIDTH (CNT_W),
      .MAX   (MAX_WAIT)
   ) u_wait (
      .clk   (clk),
      .reset (reset),
      .clr   (gnt1 | ~bus.req1),
      .inc   (bus.req1 & ~gnt1),
      .cnt   (wait_cnt)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         rd_pending <= 1'b0;
         rd_port    <= ARB_P_CPU;
      end else begin
         rd_pending <= (gnt0 | gnt1) & ~we_win;
         rd_port    <= gnt1 ? ARB_P_AUX : ARB_P_CPU;
      end
   end

   // Reset overrides a read return already in flight.
   assign bus.rvalid0 = rd_pending & ~reset & (rd_port == ARB_P_CPU);
   assign bus.rvalid1 = rd_pending & ~reset & (rd_port == ARB_P_AUX);
   assign bus.rdata   = bus.ram_dout;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed bench for ram_arbiter: two instances (MAX_WAIT 4 and 0), each with
// a behavioural registered-output RAM.
module tb_ram_arbiter;

   logic clk = 1'b0;
   logic reset;
   int   n_chk = 0;
   int   n_err = 0;

   logic        pl_en;
   logic [13:0] pl_addr;
   logic [7:0]  pl_data;
   logic [7:0]  mem0 [0:16383];
   logic [7:0]  mem1 [0:16383];

   ram_arbiter_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(14)) b0 ();
   ram_arbiter_if #(.DATA_WIDTH(8), .ADDRESS_WIDTH(14)) b1 ();

   ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(14), .MAX_WAIT(4)) dut0 (
      .clk(clk), .reset(reset), .bus(b0));
   ram_arbiter #(.DATA_WIDTH(8), .ADDRESS_WIDTH(14), .MAX_WAIT(0)) dut1 (
      .clk(clk), .reset(reset), .bus(b1));

   always #5 clk = ~clk;

   always @(posedge clk) begin
      if (pl_en) begin
         mem0[pl_addr] <= pl_data;
      end else if (b0.ram_we) begin
         mem0[b0.ram_addr] <= b0.ram_din;
      end
      b0.ram_dout <= mem0[b0.ram_addr];
   end

   always @(posedge clk) begin
      if (b1.ram_we) mem1[b1.ram_addr] <= b1.ram_din;
      b1.ram_dout <= mem1[b1.ram_addr];
   end

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_chk++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Inputs change on the falling edge; outputs are sampled 2 ns later.
   task automatic cyc();
      @(negedge clk);
   endtask

   task automatic idle_all();
      b0.req0 = 0; b0.req1 = 0; b0.we0 = 0; b0.we1 = 0;
      b0.addr0 = '0; b0.addr1 = '0; b0.wdata0 = '0; b0.wdata1 = '0;
      b1.req0 = 0; b1.req1 = 0; b1.we0 = 0; b1.we1 = 0;
      b1.addr0 = '0; b1.addr1 = '0; b1.wdata0 = '0; b1.wdata1 = '0;
   endtask

   initial begin
      logic prev_g0, prev_g1;
      reset = 1'b1;
      pl_en = 1'b0; pl_addr = '0; pl_data = '0;
      idle_all();

      // preload RAM 0 while held in reset
      cyc(); pl_en = 1; pl_addr = 14'h0123; pl_data = 8'h5A;
      cyc(); pl_addr = 14'h0010; pl_data = 8'h11;
      cyc(); pl_addr = 14'h0020; pl_data = 8'h22;
      cyc(); pl_en = 0;

      // requests during reset: nothing granted, nothing written
      b0.req0 = 1; b0.we0 = 1; b0.req1 = 1; b0.we1 = 1;
      #2;
      chk("rst_gnt0", b0.gnt0, 0);
      chk("rst_gnt1", b0.gnt1, 0);
      chk("rst_ram_we", b0.ram_we, 0);
      chk("rst_rvalid0", b0.rvalid0, 0);
      chk("rst_rvalid1", b0.rvalid1, 0);
      chk("rst_wait_cnt", dut0.wait_cnt, 0);
      cyc(); idle_all(); reset = 0;

      // uncontested port 0 read
      cyc(); b0.req0 = 1; b0.we0 = 0; b0.addr0 = 14'h0123;
      #2;
      chk("rd0_gnt0", b0.gnt0, 1);
      chk("rd0_gnt1", b0.gnt1, 0);
      chk("rd0_ram_addr", b0.ram_addr, 14'h0123);
      chk("rd0_ram_we", b0.ram_we, 0);
      cyc(); b0.req0 = 0;
      #2;
      chk("rd0_rvalid0", b0.rvalid0, 1);
      chk("rd0_rdata", b0.rdata, 8'h5A);
      chk("rd0_rvalid1", b0.rvalid1, 0);

      // port 1 write then read of the top address
      cyc(); b0.req1 = 1; b0.we1 = 1; b0.addr1 = 14'h3FFF; b0.wdata1 = 8'hA5;
      #2;
      chk("wr1_gnt1", b0.gnt1, 1);
      chk("wr1_ram_we", b0.ram_we, 1);
      chk("wr1_ram_addr", b0.ram_addr, 14'h3FFF);
      chk("wr1_ram_din", b0.ram_din, 8'hA5);
      cyc(); b0.we1 = 0;
      #2;
      chk("rd1_gnt1", b0.gnt1, 1);
      chk("rd1_ram_we", b0.ram_we, 0);
      chk("wr1_no_rvalid1", b0.rvalid1, 0);
      chk("wr1_no_rvalid0", b0.rvalid0, 0);
      cyc(); b0.req1 = 0;
      #2;
      chk("rd1_rvalid1", b0.rvalid1, 1);
      chk("rd1_rdata", b0.rdata, 8'hA5);

      // alternating reads, port 0 then port 1
      cyc(); b0.req0 = 1; b0.we0 = 0; b0.addr0 = 14'h0010;
      #2;
      chk("alt_gnt0", b0.gnt0, 1);
      cyc(); b0.req0 = 0; b0.req1 = 1; b0.we1 = 0; b0.addr1 = 14'h0020;
      #2;
      chk("alt_gnt1", b0.gnt1, 1);
      chk("alt_ram_addr1", b0.ram_addr, 14'h0020);
      chk("alt_rvalid0", b0.rvalid0, 1);
      chk("alt_rdata0", b0.rdata, 8'h11);
      cyc(); b0.req1 = 0;
      #2;
      chk("alt_rvalid1", b0.rvalid1, 1);
      chk("alt_rvalid0_lo", b0.rvalid0, 0);
      chk("alt_rdata1", b0.rdata, 8'h22);
      chk("idle_ram_addr", b0.ram_addr, 14'h0010);

      // continuous contention with MAX_WAIT = 4: period of 5, port 1 on the 5th
      cyc(); b0.req0 = 1; b0.req1 = 1; b0.we0 = 0; b0.we1 = 0;
      prev_g0 = 0; prev_g1 = 0;
      for (int i = 0; i < 15; i++) begin
         #2;
         chk($sformatf("cont_gnt1_%0d", i), b0.gnt1, ((i % 5) == 4) ? 1 : 0);
         chk($sformatf("cont_gnt0_%0d", i), b0.gnt0, ((i % 5) == 4) ? 0 : 1);
         if (i > 0) begin
            chk($sformatf("cont_rv0_%0d", i), b0.rvalid0, prev_g0);
            chk($sformatf("cont_rv1_%0d", i), b0.rvalid1, prev_g1);
         end
         prev_g0 = ((i % 5) != 4);
         prev_g1 = ((i % 5) == 4);
         cyc();
      end
      b0.req0 = 0; b0.req1 = 0;

      // MAX_WAIT = 0: pure fixed priority
      b1.req0 = 1; b1.req1 = 1; b1.addr0 = 14'h0001; b1.addr1 = 14'h0002;
      for (int i = 0; i < 20; i++) begin
         #2;
         chk($sformatf("fix_gnt1_%0d", i), b1.gnt1, 0);
         chk($sformatf("fix_gnt0_%0d", i), b1.gnt0, 1);
         cyc();
      end
      b1.req0 = 0;
      #2;
      chk("fix_release_gnt1", b1.gnt1, 1);
      chk("fix_release_addr", b1.ram_addr, 14'h0002);
      cyc(); b1.req1 = 0;

      // reset in the cycle after a granted read
      b0.req0 = 1; b0.req1 = 1; b0.addr0 = 14'h0123;
      #2;
      chk("rr_gnt0", b0.gnt0, 1);
      cyc(); b0.req0 = 0; reset = 1;
      #2;
      chk("rr_rvalid0", b0.rvalid0, 0);
      chk("rr_gnt1", b0.gnt1, 0);
      chk("rr_gnt0_lo", b0.gnt0, 0);
      cyc();
      #2;
      chk("rr_wait_cnt", dut0.wait_cnt, 0);
      chk("rr_gnt1_held", b0.gnt1, 0);
      chk("rr_rvalid0_held", b0.rvalid0, 0);
      cyc(); reset = 0; b0.req1 = 0;
      #2;
      chk("post_rst_rvalid0", b0.rvalid0, 0);
      chk("post_rst_rvalid1", b0.rvalid1, 0);
      cyc();

      $display("CHECKS %0d ERRORS %0d", n_chk, n_err);
      $finish;
   end

endmodule
